// File: rtl/stack_pkg.sv
// Shared types and constants for the stack sequencer.
// Included by stack_ptr and stack_seq.
package stack_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH      = 2'd1,
        PULL      = 2'd2,
        PULL_LAST = 2'd3
    } state_t;

    localparam logic [1:0] W8  = 2'd1;
    localparam logic [1:0] W16 = 2'd2;
    localparam logic [1:0] W24 = 2'd3;

    localparam logic [7:0]  DEF_STACK_PAGE = 8'h00;
    localparam logic [15:0] DEF_S_INIT     = 16'hFFFF;

    // Width code 0 behaves as a single byte.
    function automatic logic [1:0] byte_count(input logic [1:0] w);
        case (w)
            W16:     byte_count = W16;
            W24:     byte_count = W24;
            default: byte_count = W8;
        endcase
    endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register with load, step and optional wrap flag.
// The wrap flag logic exists only when STACK_OVF_EN is defined.
module stack_ptr
    import stack_pkg::*;
#(
    parameter logic [15:0] S_INIT = DEF_S_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [15:0] ld_val,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] s,
    output logic [15:0] s_plus1,
    output logic        ovf
);

    assign s_plus1 = s + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= S_INIT;
        end else if (ld) begin
            s <= ld_val;
        end else if (inc) begin
            s <= s_plus1;
        end else if (dec) begin
            s <= s - 16'd1;
        end
    end

`ifdef STACK_OVF_EN
    always_ff @(posedge clk) begin
        if (rst || ld) begin
            ovf <= 1'b0;
        end else if ((inc && s == 16'hFFFF) || (dec && s == 16'h0000)) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/stack_seq.sv
// Byte-serial push/pull sequencer for a 1..3 byte stack in one page.
// Define STACK_OVF_EN to enable the sticky wrap flag on ovf.
module stack_seq
    import stack_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE,
    parameter logic [15:0] S_INIT     = DEF_S_INIT
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        req_push,
    input  logic        req_pull,
    input  logic [1:0]  width,
    input  logic [23:0] wdata,
    input  logic        txs,
    input  logic [15:0] txs_val,
    input  logic        RDY,
    input  logic [7:0]  DI,
    output logic [23:0] AB,
    output logic [7:0]  DO,
    output logic        WE,
    output logic [15:0] S,
    output logic        busy,
    output logic        done,
    output logic [23:0] rdata,
    output logic        ovf
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  rd_idx_q;
    logic        pend_q;
    logic        done_q;
    logic [23:0] wdata_q;
    logic [23:0] rdata_q, rdata_nxt;
    logic [15:0] s_plus1;
    logic        ld, inc, dec;

    stack_ptr #(.S_INIT(S_INIT)) u_ptr (
        .clk    (clk),
        .rst    (RST),
        .ld     (ld),
        .ld_val (txs_val),
        .inc    (inc),
        .dec    (dec),
        .s      (S),
        .s_plus1(s_plus1),
        .ovf    (ovf)
    );

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        AB      = {STACK_PAGE, S};
        DO      = 8'h00;
        WE      = 1'b0;
        case (state_q)
            IDLE: begin
                if (RDY) begin
                    if (txs)           ld      = 1'b1;
                    else if (req_push) state_d = PUSH;
                    else if (req_pull) state_d = PULL;
                end
            end
            PUSH: begin
                WE = 1'b1;
                case (cnt_q)
                    2'd3:    DO = wdata_q[23:16];
                    2'd2:    DO = wdata_q[15:8];
                    default: DO = wdata_q[7:0];
                endcase
                if (RDY) begin
                    dec = 1'b1;
                    if (cnt_q == 2'd1) state_d = IDLE;
                end
            end
            PULL: begin
                AB = {STACK_PAGE, s_plus1};
                if (RDY) begin
                    inc = 1'b1;
                    if (cnt_q == 2'd1) state_d = PULL_LAST;
                end
            end
            PULL_LAST: begin
                if (RDY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data lands one cycle after its address, low byte first.
    always_comb begin
        rdata_nxt = rdata_q;
        case (rd_idx_q)
            2'd0:    rdata_nxt[7:0]   = DI;
            2'd1:    rdata_nxt[15:8]  = DI;
            2'd2:    rdata_nxt[23:16] = DI;
            default: rdata_nxt        = rdata_q;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q | (state_q == PULL_LAST && RDY);
    assign rdata = (state_q == PULL_LAST) ? rdata_nxt : rdata_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            rd_idx_q <= 2'd0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            wdata_q  <= 24'h0;
            rdata_q  <= 24'h0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (RDY) begin
                case (state_q)
                    IDLE: begin
                        if (!txs && req_push) begin
                            wdata_q <= wdata;
                            cnt_q   <= byte_count(width);
                        end else if (!txs && req_pull) begin
                            cnt_q    <= byte_count(width);
                            rdata_q  <= 24'h0;
                            rd_idx_q <= 2'd0;
                            pend_q   <= 1'b0;
                        end
                    end
                    PUSH: begin
                        cnt_q <= cnt_q - 2'd1;
                        if (cnt_q == 2'd1) done_q <= 1'b1;
                    end
                    PULL: begin
                        cnt_q  <= cnt_q - 2'd1;
                        pend_q <= 1'b1;
                        if (pend_q) begin
                            rdata_q  <= rdata_nxt;
                            rd_idx_q <= rd_idx_q + 2'd1;
                        end
                    end
                    PULL_LAST: begin
                        rdata_q <= rdata_nxt;
                        pend_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
